note_reader: RTL

Beat-driven reader for the song note memory: consumes the one-cycle beat tick from the tempo clock divider and, on each accepted beat, fetches the next 32-bit note word from the 64-word synchronous note RAM and presents it to the game datapath. Sits between the tempo divider (producer of `beat`) and the lane/display logic (consumer of `note_data`). Handles start, pause, end-of-song detection and restart.

---
 rtl/note_pkg.sv | 21 ++
 rtl/note_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared definitions for the song note reader: the reader FSM state type,
// the note word layout (bit 31 flags end-of-song) and the default address and
// data widths of the 64x32 note RAM.
// -----------------------------------------------------------------------------
package note_pkg;

    localparam int NOTE_END_BIT = 31;
    localparam int NOTE_ADDR_W  = 6;
    localparam int NOTE_DATA_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BEAT = 3'd1,
        ST_FETCH     = 3'd2,
        ST_LATCH     = 3'd3,
        ST_DONE      = 3'd4
    } note_state_e;

endpackage

// File: rtl/note_reader.sv
// -----------------------------------------------------------------------------
// note_reader
// Beat-driven reader for the song note memory. Each accepted beat fetches the
// next note word from an external synchronous note RAM (one-cycle read
// latency) and presents its payload to the game datapath.
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   beat       in   one-cycle beat tick from the tempo divider
//   start      in   one-cycle pulse, begins or restarts playback
//   pause      in   level, suppresses beat acceptance while high
//   ram_addr   out  note RAM read address (registered)
//   ram_q      in   note RAM read data, valid one cycle after ram_addr
//   note_valid out  one-cycle pulse, note_data/beat_index updated
//   note_data  out  payload bits [30:0] of the fetched word
//   beat_index out  RAM address of the word behind note_data
//   playing    out  high while a song is in progress
//   done       out  high once the song has ended
//
// Build option:
//   NOTE_READER_LOOP_EN  when defined, the song wraps back to address 0 at its
//                        end instead of stopping; done then pulses once per
//                        wrap and playing stays high.
// -----------------------------------------------------------------------------
module note_reader
    import note_pkg::*;
#(
    parameter int ADDR_W   = NOTE_ADDR_W,
    parameter int DATA_W   = NOTE_DATA_W,
    parameter int SONG_LEN = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              beat,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              note_valid,
    output logic [DATA_W-2:0] note_data,
    output logic [ADDR_W-1:0] beat_index,
    output logic              playing,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

    note_state_e       r_state;
    note_state_e       w_next_state;

    logic [ADDR_W-1:0] r_ram_addr;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic [ADDR_W-1:0] r_beat_index;
    logic [ADDR_W-1:0] w_beat_index_nxt;
    logic [DATA_W-2:0] r_note_data;
    logic [DATA_W-2:0] w_note_data_nxt;
    logic              r_note_valid;
    logic              w_note_valid_nxt;
    logic              r_playing;
    logic              w_playing_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_end_marker;
    logic              w_last_addr;
    logic              w_stop;

    // A fetched word ends the song either by carrying the END flag or by
    // sitting at the last playable address.
    assign w_end_marker = ram_q[NOTE_END_BIT];
    assign w_last_addr  = (r_ram_addr == LAST_ADDR);
    assign w_stop       = w_end_marker | w_last_addr;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_WAIT_BEAT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_BEAT: begin
                // A beat arriving while paused is dropped, not queued.
                if (beat && !pause) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_WAIT_BEAT;
                end
            end
            ST_FETCH: begin
                w_next_state = ST_LATCH;
            end
            ST_LATCH: begin
                if (w_stop) begin
`ifdef NOTE_READER_LOOP_EN
                    w_next_state = ST_WAIT_BEAT;
`else
                    w_next_state = ST_DONE;
`endif
                end else begin
                    w_next_state = ST_WAIT_BEAT;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_next_state = ST_WAIT_BEAT;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_ram_addr_nxt   = r_ram_addr;
        w_note_valid_nxt = 1'b0;
        w_note_data_nxt  = r_note_data;
        w_beat_index_nxt = r_beat_index;
        w_done_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ram_addr_nxt = ADDR_ZERO;
            end
            ST_DONE: begin
                if (start) begin
                    w_ram_addr_nxt = ADDR_ZERO;
                end else begin
                    w_ram_addr_nxt = r_ram_addr;
                end
            end
            ST_LATCH: begin
                // An END word is consumed silently; everything else is shown.
                if (!w_end_marker) begin
                    w_note_valid_nxt = 1'b1;
                    w_note_data_nxt  = ram_q[DATA_W-2:0];
                    w_beat_index_nxt = r_ram_addr;
                end else begin
                    w_note_valid_nxt = 1'b0;
                end
                if (w_stop) begin
`ifdef NOTE_READER_LOOP_EN
                    w_ram_addr_nxt = ADDR_ZERO;
                    w_done_nxt     = 1'b1;
`else
                    w_ram_addr_nxt = r_ram_addr;
`endif
                end else begin
                    w_ram_addr_nxt = r_ram_addr + ADDR_ONE;
                end
            end
            default: begin
                w_ram_addr_nxt = r_ram_addr;
            end
        endcase
`ifndef NOTE_READER_LOOP_EN
        w_done_nxt = (w_next_state == ST_DONE);
`endif
        w_playing_nxt = (w_next_state == ST_WAIT_BEAT) ||
                        (w_next_state == ST_FETCH)     ||
                        (w_next_state == ST_LATCH);
    end

    // Output and datapath registers; reset discards any in-flight fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ram_addr   <= {ADDR_W{1'b0}};
            r_note_valid <= 1'b0;
            r_note_data  <= {(DATA_W-1){1'b0}};
            r_beat_index <= {ADDR_W{1'b0}};
            r_playing    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_ram_addr   <= w_ram_addr_nxt;
            r_note_valid <= w_note_valid_nxt;
            r_note_data  <= w_note_data_nxt;
            r_beat_index <= w_beat_index_nxt;
            r_playing    <= w_playing_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign ram_addr   = r_ram_addr;
    assign note_valid = r_note_valid;
    assign note_data  = r_note_data;
    assign beat_index = r_beat_index;
    assign playing    = r_playing;
    assign done       = r_done;

endmodule
